// File: rtl/mm_job_scheduler.sv
// mm_job_scheduler: round-robin arbiter sharing one compute_unit among NUM_REQ job requesters
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_slot        per-requester job request and BRAM buffer slot
//   req_ready                 one-hot grant, only ever asserted in IDLE
//   cu_start/cu_slot/cu_done  compute_unit start pulse, slot select and done pulse
//   cmp_valid/id/slot/err     tagged completion, held until cmp_ready
//   busy, jobs_done           activity flag and count of accepted completions
//   `define MM_SCHED_TIMEOUT_EN  aborts a RUN after TIMEOUT_CYC cycles with cmp_err=1
module mm_job_scheduler #(
   parameter int NUM_REQ     = 4,
   parameter int SLOT_W      = 2,
   parameter int TIMEOUT_CYC = 1024,
   parameter int CNT_W       = 16
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_REQ-1:0]                 req_valid,
   input  logic [NUM_REQ-1:0][SLOT_W-1:0]     req_slot,
   output logic [NUM_REQ-1:0]                 req_ready,
   output logic                               cu_start,
   output logic [SLOT_W-1:0]                  cu_slot,
   input  logic                               cu_done,
   output logic                               cmp_valid,
   output logic [$clog2(NUM_REQ)-1:0]         cmp_id,
   output logic [SLOT_W-1:0]                  cmp_slot,
   output logic                               cmp_err,
   input  logic                               cmp_ready,
   output logic                               busy,
   output logic [CNT_W-1:0]                   jobs_done
);
   localparam int ID_W = $clog2(NUM_REQ);
   typedef enum logic [1:0] {IDLE, LAUNCH, RUN, REPORT} state_t;
   state_t              state_q, state_d;
   logic [ID_W-1:0]     rr_q, rr_d, id_q, id_d, g;
   logic [SLOT_W-1:0]   slot_q, slot_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ID_W:0]       k;
   logic                any;
`ifdef MM_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC) + 1;
   logic [TW-1:0]       timer_q, timer_d;
   logic                err_q, err_d;
`endif
   // Circular search starting at rr_q; k wraps without a modulo so NUM_REQ need not be a power of 2
   always_comb begin
      any = 1'b0;
      g = '0;
      k = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         k = {1'b0, rr_q} + (ID_W+1)'(i);
         k = (k >= (ID_W+1)'(NUM_REQ)) ? k - (ID_W+1)'(NUM_REQ) : k;
         if (!any && req_valid[k[ID_W-1:0]]) begin
            any = 1'b1;
            g = k[ID_W-1:0];
         end
      end
   end
   always_comb begin
      state_d = state_q;
      rr_d = rr_q;
      id_d = id_q;
      slot_d = slot_q;
      cnt_d = cnt_q;
`ifdef MM_SCHED_TIMEOUT_EN
      err_d = err_q;
      timer_d = (state_q == RUN) ? timer_q + 1'b1 : '0;
`endif
      case (state_q)
         IDLE: if (any) begin
            state_d = LAUNCH;
            id_d = g;
            slot_d = req_slot[g];
            rr_d = (g == ID_W'(NUM_REQ-1)) ? '0 : g + 1'b1;
         end
         LAUNCH: state_d = RUN;
         RUN: begin
`ifdef MM_SCHED_TIMEOUT_EN
            // cu_done arriving on the final timer cycle takes priority over the abort
            if (cu_done || timer_q == TW'(TIMEOUT_CYC-1)) begin
               state_d = REPORT;
               err_d = !cu_done;
            end
`else
            if (cu_done) state_d = REPORT;
`endif
         end
         REPORT: if (cmp_ready) begin
            state_d = IDLE;
            cnt_d = cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rr_q <= '0;
         id_q <= '0;
         slot_q <= '0;
         cnt_q <= '0;
`ifdef MM_SCHED_TIMEOUT_EN
         timer_q <= '0;
         err_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rr_q <= rr_d;
         id_q <= id_d;
         slot_q <= slot_d;
         cnt_q <= cnt_d;
`ifdef MM_SCHED_TIMEOUT_EN
         timer_q <= timer_d;
         err_q <= err_d;
`endif
      end
   end
   assign req_ready = (state_q == IDLE && any) ? NUM_REQ'(1) << g : '0;
   assign cu_start  = state_q == LAUNCH;
   assign cu_slot   = (state_q == LAUNCH || state_q == RUN) ? slot_q : '0;
   assign cmp_valid = state_q == REPORT;
   assign cmp_id    = (state_q == REPORT) ? id_q : '0;
   assign cmp_slot  = (state_q == REPORT) ? slot_q : '0;
`ifdef MM_SCHED_TIMEOUT_EN
   assign cmp_err   = (state_q == REPORT) && err_q;
`else
   assign cmp_err   = 1'b0;
`endif
   assign busy      = state_q != IDLE;
   assign jobs_done = cnt_q;
endmodule

// File: tb/tb_mm_job_scheduler.sv
// tb_mm_job_scheduler: scoreboard bench for mm_job_scheduler
module tb_mm_job_scheduler;
   localparam int TO = 16;
   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [3:0]       req_valid = '0;
   logic [3:0][1:0]  req_slot;
   logic [3:0]       req_ready;
   logic             cu_start, cu_done = 1'b0;
   logic [1:0]       cu_slot, cmp_id, cmp_slot;
   logic             cmp_valid, cmp_err, cmp_ready = 1'b0, busy;
   logic [15:0]      jobs_done;
   logic [1:0]       slot_m [4] = '{2'd2, 2'd0, 2'd3, 2'd1};
   logic [4:0]       sb [$];
   int               rr_m = 0, jobs_m = 0, nchk = 0, nerr = 0;

   mm_job_scheduler #(.NUM_REQ(4), .SLOT_W(2), .TIMEOUT_CYC(TO), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_slot(req_slot), .req_ready(req_ready),
      .cu_start(cu_start), .cu_slot(cu_slot), .cu_done(cu_done), .cmp_valid(cmp_valid),
      .cmp_id(cmp_id), .cmp_slot(cmp_slot), .cmp_err(cmp_err), .cmp_ready(cmp_ready),
      .busy(busy), .jobs_done(jobs_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // dly < 0 means no cu_done: the job must end by timeout
   task automatic run_job(input logic [3:0] mask, input int dly, input int bp);
      int g;
      logic [4:0] e;
      g = -1;
      for (int i = 0; i < 4; i++) if (g < 0 && mask[(rr_m + i) % 4]) g = (rr_m + i) % 4;
      req_valid = mask;
      #1;
      chk("grant", 32'(req_ready), 32'(1) << g);
      sb.push_back({g[1:0], slot_m[g], dly < 0});
      @(posedge clk);
      rr_m = (g + 1) % 4;
      @(negedge clk);
      chk("start", 32'(cu_start), 1);
      chk("launch_slot", 32'(cu_slot), 32'(slot_m[g]));
      chk("launch_no_grant", 32'(req_ready), 0);
      @(negedge clk);
      chk("start_pulse", 32'(cu_start), 0);
      chk("run_slot", 32'(cu_slot), 32'(slot_m[g]));
      if (dly < 0) begin
         repeat (TO - 1) @(negedge clk);
         chk("pre_timeout", 32'(cmp_valid), 0);
         @(negedge clk);
      end else begin
         repeat (dly) @(negedge clk);
         chk("run_wait", 32'(cmp_valid), 0);
         cu_done = 1'b1;
         @(negedge clk);
         cu_done = 1'b0;
      end
      e = sb.pop_front();
      chk("cmp_valid", 32'(cmp_valid), 1);
      chk("cmp_id", 32'(cmp_id), 32'(e[4:3]));
      chk("cmp_slot", 32'(cmp_slot), 32'(e[2:1]));
      chk("cmp_err", 32'(cmp_err), 32'(e[0]));
      for (int i = 0; i < bp; i++) begin
         cu_done = (i == 0);
         @(negedge clk);
         chk("bp_valid", 32'(cmp_valid), 1);
         chk("bp_id", 32'(cmp_id), 32'(e[4:3]));
         chk("bp_err", 32'(cmp_err), 32'(e[0]));
         chk("bp_start", 32'(cu_start), 0);
         chk("bp_grant", 32'(req_ready), 0);
         chk("bp_jobs", 32'(jobs_done), 32'(jobs_m));
      end
      cu_done = 1'b0;
      cmp_ready = 1'b1;
      @(negedge clk);
      cmp_ready = 1'b0;
      req_valid = '0;
      jobs_m++;
      chk("jobs_done", 32'(jobs_done), 32'(jobs_m));
      chk("idle_busy", 32'(busy), 0);
      chk("idle_valid", 32'(cmp_valid), 0);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) req_slot[i] = slot_m[i];
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_start", 32'(cu_start), 0);
      chk("rst_slot", 32'(cu_slot), 0);
      chk("rst_valid", 32'(cmp_valid), 0);
      chk("rst_jobs", 32'(jobs_done), 0);
      chk("rst_ready", 32'(req_ready), 0);
      run_job(4'b0100, 40, 0);
      cu_done = 1'b1;
      @(negedge clk);
      cu_done = 1'b0;
      @(negedge clk);
      chk("stray_idle_busy", 32'(busy), 0);
      chk("stray_idle_jobs", 32'(jobs_done), 32'(jobs_m));
      for (int j = 0; j < 8; j++) run_job(4'hF, 3 + j, 0);
      run_job(4'b1010, 5, 10);
      run_job(4'b1010, 5, 0);
      req_valid = 4'b0100;
      @(posedge clk);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rr_m = 0;
      jobs_m = 0;
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_slot", 32'(cu_slot), 0);
      chk("mid_rst_jobs", 32'(jobs_done), 0);
      cu_done = 1'b1;
      @(negedge clk);
      cu_done = 1'b0;
      @(negedge clk);
      chk("late_done_busy", 32'(busy), 0);
      chk("late_done_valid", 32'(cmp_valid), 0);
      run_job(4'b1001, 4, 0);
      run_job(4'b0010, 4, 0);
`ifdef MM_SCHED_TIMEOUT_EN
      run_job(4'b0001, -1, 3);
      run_job(4'b0001, TO - 1, 0);
`endif
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
